// File: rtl/mul_unit_scheduler.sv
// Issue/writeback controller for the shared pipelined multiplier: round-robin issue from the
// reservation stations, a tag pipe alongside the datapath and a credit-protected result FIFO.
module mul_unit_scheduler #(
    parameter int NUM_RS     = 4,
    parameter int TAG_W      = 4,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RS-1:0]       rs_req,
    input  logic [NUM_RS*TAG_W-1:0] rs_tag,
    input  logic [NUM_RS*32-1:0]    rs_a,
    input  logic [NUM_RS*32-1:0]    rs_b,
    output logic [NUM_RS-1:0]       rs_grant,
    output logic                    mul_valid,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    input  logic [63:0]             mul_product,
    output logic                    cdb_req,
    input  logic                    cdb_grant,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [63:0]             cdb_data,
    input  logic                    flush,
    output logic                    busy
);
    localparam int RR_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int FP_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(LAT + FIFO_DEPTH + 1);
    localparam int ENT_W = TAG_W + 64;

    function automatic logic [CNT_W-1:0] count_valid(input logic [LAT-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < LAT; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [FP_W-1:0] fifo_inc(input logic [FP_W-1:0] p);
        return (p == FP_W'(FIFO_DEPTH - 1)) ? '0 : p + FP_W'(1);
    endfunction

    // Returns {found, index}: first requester at or above ptr, wrapping around.
    function automatic logic [RR_W:0] rr_pick(input logic [NUM_RS-1:0] req,
                                               input logic [RR_W-1:0]   ptr);
        logic [NUM_RS-1:0] rot;
        logic [RR_W:0]     idx;
        logic [RR_W:0]     res;
        rot = NUM_RS'({req, req} >> ptr);
        res = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (RR_W+1)'(i);
            idx = (idx >= (RR_W+1)'(NUM_RS)) ? idx - (RR_W+1)'(NUM_RS) : idx;
            res = rot[i] ? {1'b1, idx[RR_W-1:0]} : res;
        end
        return res;
    endfunction

    logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              mul_valid_q, mul_valid_d;
    logic [31:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [LAT-1:0]    tag_v_q, tag_v_d;
    logic [TAG_W-1:0]  tag_pipe_q [LAT];
    logic [TAG_W-1:0]  tag_pipe_d [LAT];
    logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  fifo_d [FIFO_DEPTH];
    logic [FP_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;

    logic [CNT_W-1:0]  inflight_s;
    logic              can_issue_s;
    logic [RR_W:0]     pick_s;
    logic              grant_any_s;
    logic [RR_W-1:0]   grant_idx_s;
    logic [NUM_RS-1:0] grant_s;
    logic [TAG_W-1:0]  tag_sel_s;
    logic [31:0]       a_sel_s, b_sel_s;
    logic              push_s, pop_s;

    // Credit check, round-robin pick and operand selection for the granted station.
    always_comb begin
        inflight_s  = count_valid(tag_v_q);
        can_issue_s = rst_n && !flush && ((inflight_s + occ_q) < CNT_W'(FIFO_DEPTH));
        pick_s      = rr_pick(rs_req, rr_ptr_q);
        grant_any_s = can_issue_s && pick_s[RR_W];
        grant_idx_s = pick_s[RR_W-1:0];
        grant_s     = grant_any_s ? (NUM_RS'(1) << grant_idx_s) : '0;
        tag_sel_s   = '0;
        a_sel_s     = '0;
        b_sel_s     = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            tag_sel_s = tag_sel_s | (rs_tag[i*TAG_W +: TAG_W] & {TAG_W{grant_s[i]}});
            a_sel_s   = a_sel_s   | (rs_a[i*32 +: 32] & {32{grant_s[i]}});
            b_sel_s   = b_sel_s   | (rs_b[i*32 +: 32] & {32{grant_s[i]}});
        end
    end

    // Next state of issue registers, tag pipe and result FIFO; flush overrides everything.
    always_comb begin
        push_s      = tag_v_q[LAT-1];
        pop_s       = (occ_q != '0) && cdb_grant && !flush;
        rr_ptr_d    = rr_ptr_q;
        mul_valid_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        tag_v_d     = tag_v_q;
        tag_pipe_d  = tag_pipe_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        if (flush) begin
            tag_v_d  = '0;
            occ_d    = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (grant_any_s) begin
                rr_ptr_d    = (grant_idx_s == RR_W'(NUM_RS - 1)) ? '0 : grant_idx_s + RR_W'(1);
                mul_valid_d = 1'b1;
                mul_a_d     = a_sel_s;
                mul_b_d     = b_sel_s;
            end else begin
                mul_valid_d = 1'b0;
            end
            tag_v_d[0]    = grant_any_s;
            tag_pipe_d[0] = tag_sel_s;
            for (int i = 1; i < LAT; i++) begin
                tag_v_d[i]    = tag_v_q[i-1];
                tag_pipe_d[i] = tag_pipe_q[i-1];
            end
            if (push_s) begin
                fifo_d[wr_ptr_q] = {tag_pipe_q[LAT-1], mul_product};
                wr_ptr_d         = fifo_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = fifo_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_v_q     <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_pipe_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_v_q     <= tag_v_d;
            tag_pipe_q  <= tag_pipe_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    assign rs_grant  = grant_s;
    assign mul_valid = mul_valid_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign cdb_req   = (occ_q != '0);
    assign cdb_tag   = fifo_q[rd_ptr_q][ENT_W-1:64];
    assign cdb_data  = fifo_q[rd_ptr_q][63:0];
    assign busy      = (inflight_s != '0) || (occ_q != '0) || mul_valid_q;

endmodule

// File: tb/tb_mul_unit_scheduler.sv
// Scoreboard bench for mul_unit_scheduler with a 3-stage multiplier datapath model.
module tb_mul_unit_scheduler;
    localparam int NUM_RS = 4, TAG_W = 4, LAT = 3, FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [NUM_RS-1:0]       rs_req;
    logic [NUM_RS*TAG_W-1:0] rs_tag;
    logic [NUM_RS*32-1:0]    rs_a, rs_b;
    logic [NUM_RS-1:0]       rs_grant;
    logic                    mul_valid;
    logic [31:0]             mul_a, mul_b;
    logic [63:0]             mul_product;
    logic                    cdb_req, cdb_grant;
    logic [TAG_W-1:0]        cdb_tag;
    logic [63:0]             cdb_data;
    logic                    flush, busy;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mul_unit_scheduler #(.NUM_RS(NUM_RS), .TAG_W(TAG_W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rs_req(rs_req), .rs_tag(rs_tag), .rs_a(rs_a), .rs_b(rs_b),
        .rs_grant(rs_grant), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath model: product appears LAT edges after the operands are launched.
    logic [63:0] dp1, dp2;
    always @(posedge clk) begin
        dp1 <= {32'h0, mul_a} * {32'h0, mul_b};
        dp2 <= dp1;
    end
    assign mul_product = dp2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every result accepted by the CDB is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && cdb_req && cdb_grant) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cdb_unexpected: got tag %0h data %0h expected none", cdb_tag, cdb_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("cdb_tag", 64'(cdb_tag), 64'(mon_e.tag));
                check("cdb_data", cdb_data, mon_e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input int i, input logic req, input logic [TAG_W-1:0] tag,
                          input logic [31:0] a, input logic [31:0] b);
        rs_req[i]                = req;
        rs_tag[i*TAG_W +: TAG_W] = tag;
        rs_a[i*32 +: 32]         = a;
        rs_b[i*32 +: 32]         = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rs_req    = '0;
        cdb_grant = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        int n;
        n         = 0;
        rs_req    = '0;
        cdb_grant = 1'b1;
        while ((busy || exp_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] rr_exp [6];
        logic [3:0] exp_g;
        int n;
        int c;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
        rs_req = '0; rs_tag = '0; rs_a = '0; rs_b = '0;
        cdb_grant = 1'b0; flush = 1'b0; rst_n = 1'b0;

        // Reset state, with requests present to show the grant is held off.
        rs_req = 4'b1111;
        #12;
        check("rst_grant", 64'(rs_grant), 64'd0);
        check("rst_mul_valid", 64'(mul_valid), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_cdb_req", 64'(cdb_req), 64'd0);
        check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        check("rst_cdb_data", cdb_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rs_req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single op: 7 * 9, tag 5.
        cdb_grant = 1'b1;
        set_rs(1, 1'b1, 4'h5, 32'h7, 32'h9);
        @(negedge clk);
        check("t1_grant", 64'(rs_grant), 64'b0010);
        exp_q.push_back({4'h5, 64'h3F});
        step();
        set_rs(1, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("t1_mul_valid", 64'(mul_valid), 64'd1);
        check("t1_mul_a", 64'(mul_a), 64'd7);
        check("t1_mul_b", 64'(mul_b), 64'd9);
        step();
        step();
        @(negedge clk);
        check("t1_cdb_req_early", 64'(cdb_req), 64'd0);
        step();
        @(negedge clk);
        check("t1_cdb_req", 64'(cdb_req), 64'd1);
        step();
        @(negedge clk);
        check("t1_busy_after_pop", 64'(busy), 64'd0);
        check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // Round-robin with all stations requesting; the credit limit inserts one idle slot.
        do_reset();
        cdb_grant = 1'b1;
        for (int i = 0; i < NUM_RS; i++) set_rs(i, 1'b1, 4'(8 + i), 32'(i + 1), 32'h10);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_grant", 64'(rs_grant), 64'(rr_exp[k]));
            for (int j = 0; j < NUM_RS; j++) begin
                if (rr_exp[k][j]) exp_q.push_back({4'(8 + j), 64'((j + 1) * 16)});
            end
            step();
        end
        drain("rr");

        // Backpressure: four credits, the fifth op waits for the first pop.
        do_reset();
        n = 0;
        for (int k = 0; k < 12; k++) begin
            cdb_grant = (k >= 10);
            set_rs(0, n < 5, 4'(n + 1), 32'(n + 2), 32'd3);
            @(negedge clk);
            exp_g = (k < 4 || k == 11) ? 4'b0001 : 4'b0000;
            check("bp_grant", 64'(rs_grant), 64'(exp_g));
            if (k == 9) check("bp_head_tag", 64'(cdb_tag), 64'd1);
            if (exp_g[0]) begin
                exp_q.push_back({4'(n + 1), 64'((n + 2) * 3)});
                n++;
            end
            step();
        end
        drain("bp");

        // Streaming with simultaneous push/pop, all-ones operands.
        do_reset();
        cdb_grant = 1'b1;
        n = 0;
        c = 0;
        while (n < 6 && c < 40) begin
            set_rs(2, 1'b1, 4'(n + 1), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            @(negedge clk);
            check("pp_other_grants", 64'(rs_grant & ~4'b0100), 64'd0);
            if (rs_grant[2]) begin
                exp_q.push_back({4'(n + 1), 64'hFFFF_FFFE_0000_0001});
                n++;
            end
            step();
            c++;
        end
        check("pp_issued", 64'(n), 64'd6);
        drain("pp");

        // Flush with one buffered and two in flight.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_rs(0, 1'b1, 4'(k + 1), 32'(k + 1), 32'h100);
            @(negedge clk);
            check("fl_issue_grant", 64'(rs_grant), 64'b0001);
            exp_q.push_back({4'(k + 1), 64'((k + 1) * 256)});
            step();
        end
        set_rs(0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        flush = 1'b1;
        set_rs(0, 1'b1, 4'h7, 32'h2, 32'h2);
        @(negedge clk);
        check("fl_cdb_req_before", 64'(cdb_req), 64'd1);
        check("fl_head_tag", 64'(cdb_tag), 64'd1);
        check("fl_no_grant", 64'(rs_grant), 64'd0);
        exp_q.delete();
        step();
        flush = 1'b0;
        rs_req = '0;
        @(negedge clk);
        check("fl_cdb_req_after", 64'(cdb_req), 64'd0);
        check("fl_busy_after", 64'(busy), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check("fl_no_late_result", 64'(cdb_req), 64'd0);
        end
        step();
        cdb_grant = 1'b1;
        set_rs(1, 1'b1, 4'hA, 32'h1234, 32'h10);
        @(negedge clk);
        check("fl_next_grant", 64'(rs_grant), 64'b0010);
        exp_q.push_back({4'hA, 64'h12340});
        step();
        drain("fl");

        // Asynchronous reset in the middle of a stream.
        do_reset();
        for (int i = 0; i < NUM_RS; i++) set_rs(i, 1'b1, 4'(8 + i), 32'(i + 1), 32'h10);
        repeat (4) step();
        check("ar_mul_valid_before", 64'(mul_valid), 64'd1);
        check("ar_cdb_req_before", 64'(cdb_req), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_mul_valid", 64'(mul_valid), 64'd0);
        check("ar_mul_a", 64'(mul_a), 64'd0);
        check("ar_cdb_req", 64'(cdb_req), 64'd0);
        check("ar_cdb_tag", 64'(cdb_tag), 64'd0);
        check("ar_cdb_data", cdb_data, 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_grant", 64'(rs_grant), 64'd0);
        exp_q.delete();
        rs_req = 4'b0101;
        #7;
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_first_grant", 64'(rs_grant), 64'b0001);
        exp_q.push_back({4'h8, 64'h10});
        step();
        drain("ar");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
